// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix-vector multiply read/MAC path.
package mvm_pkg;

   localparam int M_DEF          = 4;
   localparam int MAT_AW_DEF     = 4;
   localparam int VEC_AW_DEF     = 2;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int ACC_WIDTH_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   typedef logic signed [DATA_WIDTH_DEF-1:0] data_t;
   typedef logic signed [ACC_WIDTH_DEF-1:0]  acc_t;

endpackage

// File: rtl/ctrl_mvm_read_mac_unit.sv
// Signed multiply with load-or-accumulate; the sum wraps modulo 2^ACC_WIDTH.
module mac_unit
   import mvm_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         first,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   logic signed [PROD_WIDTH-1:0] prod_s;
   logic signed [ACC_WIDTH-1:0]  prod_ext_s;
   logic signed [ACC_WIDTH-1:0]  acc_d;

   // Product, resized to the accumulator, and next accumulator value
   always_comb begin
      prod_s     = PROD_WIDTH'(a) * PROD_WIDTH'(b);
      prod_ext_s = ACC_WIDTH'(prod_s);
      acc_d      = acc;
      if (!en) begin
         acc_d = acc;
      end else if (first) begin
         acc_d = prod_ext_s;
      end else begin
         acc_d = acc + prod_ext_s;
      end
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else begin
         acc <= acc_d;
      end
   end

endmodule

// File: rtl/ctrl_mvm_read.sv
// Reads a loaded M x M matrix and M-vector, emits one signed dot product per row
// on a valid/ready port, then pulses mem_release so the writers can reload.
module ctrl_mvm_read
   import mvm_pkg::*;
#(
   parameter int M              = M_DEF,
   parameter int MAT_ADDR_WIDTH = MAT_AW_DEF,
   parameter int VEC_ADDR_WIDTH = VEC_AW_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH      = ACC_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mat_loaded,
   input  logic                      vec_loaded,
   input  logic [DATA_WIDTH-1:0]     mat_rdata,
   input  logic [DATA_WIDTH-1:0]     vec_rdata,
   output logic [MAT_ADDR_WIDTH-1:0] mat_addr,
   output logic [VEC_ADDR_WIDTH-1:0] vec_addr,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [ACC_WIDTH-1:0]      m_data,
   output logic                      mem_release
);

   localparam logic [VEC_ADDR_WIDTH-1:0] LAST = VEC_ADDR_WIDTH'(M - 1);

   state_e                      state_q;
   logic [VEC_ADDR_WIDTH-1:0]   row_q;
   logic [VEC_ADDR_WIDTH-1:0]   col_q;
   logic [VEC_ADDR_WIDTH-1:0]   col_d;
   logic [MAT_ADDR_WIDTH-1:0]   mat_addr_q;
   logic [VEC_ADDR_WIDTH-1:0]   vec_addr_q;
   logic                        rd_vld_q;
   logic                        rd_first_q;
   logic                        m_valid_q;
   logic                        mem_release_q;
   logic signed [ACC_WIDTH-1:0] acc_s;

   assign col_d = col_q + VEC_ADDR_WIDTH'(1);

   // Sequencer: address counters, read-valid pipe and result handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         mat_addr_q    <= '0;
         vec_addr_q    <= '0;
         rd_vld_q      <= 1'b0;
         rd_first_q    <= 1'b0;
         m_valid_q     <= 1'b0;
         mem_release_q <= 1'b0;
      end else begin
         // Read data returns one cycle after the address, so the column tag is delayed too
         rd_vld_q      <= (state_q == READ);
         rd_first_q    <= (state_q == READ) && (col_q == '0);
         mem_release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mat_loaded && vec_loaded && !mem_release_q) begin
                  state_q    <= READ;
                  col_q      <= '0;
                  vec_addr_q <= '0;
               end
            end
            READ: begin
               mat_addr_q <= mat_addr_q + MAT_ADDR_WIDTH'(1);
               if (col_q == LAST) begin
                  state_q    <= DRAIN;
                  col_q      <= '0;
                  vec_addr_q <= '0;
               end else begin
                  col_q      <= col_d;
                  vec_addr_q <= col_d;
               end
            end
            DRAIN: begin
               state_q   <= OUT;
               m_valid_q <= 1'b1;
            end
            OUT: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  if (row_q == LAST) begin
                     state_q       <= IDLE;
                     row_q         <= '0;
                     mat_addr_q    <= '0;
                     mem_release_q <= 1'b1;
                  end else begin
                     state_q    <= READ;
                     row_q      <= row_q + VEC_ADDR_WIDTH'(1);
                     col_q      <= '0;
                     vec_addr_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .en    (rd_vld_q),
      .first (rd_first_q),
      .a     (mat_rdata),
      .b     (vec_rdata),
      .acc   (acc_s)
   );

   // The accumulator is idle (en low) throughout OUT, so it doubles as the result register
   assign mat_addr    = mat_addr_q;
   assign vec_addr    = vec_addr_q;
   assign m_valid     = m_valid_q;
   assign m_data      = acc_s;
   assign mem_release = mem_release_q;

endmodule

// File: tb/tb_ctrl_mvm_read.sv
// Directed bench for ctrl_mvm_read with behavioural 1-cycle-latency memories.
module tb_ctrl_mvm_read;

   logic        clk = 1'b0;
   logic        reset;
   logic        mat_loaded;
   logic        vec_loaded;
   logic [7:0]  mat_rdata;
   logic [7:0]  vec_rdata;
   logic [3:0]  mat_addr;
   logic [1:0]  vec_addr;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic        mem_release;

   logic [7:0]  mat_mem [16];
   logic [7:0]  vec_mem [4];
   logic [15:0] exp_rows [4];

   int checks = 0;
   int errors = 0;

   ctrl_mvm_read dut (
      .clk         (clk),
      .reset       (reset),
      .mat_loaded  (mat_loaded),
      .vec_loaded  (vec_loaded),
      .mat_rdata   (mat_rdata),
      .vec_rdata   (vec_rdata),
      .mat_addr    (mat_addr),
      .vec_addr    (vec_addr),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .mem_release (mem_release)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mat_rdata <= mat_mem[mat_addr];
      vec_rdata <= vec_mem[vec_addr];
   end

   task automatic do_reset();
      reset      = 1'b1;
      mat_loaded = 1'b0;
      vec_loaded = 1'b0;
      m_ready    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_diag();
      for (int i = 0; i < 16; i++) mat_mem[i] = 8'd0;
      mat_mem[0]  = 8'd1;
      mat_mem[5]  = 8'd2;
      mat_mem[10] = 8'hFD;
      mat_mem[15] = 8'd4;
      vec_mem[0] = 8'd5; vec_mem[1] = 8'd6; vec_mem[2] = 8'd7; vec_mem[3] = 8'd8;
      exp_rows[0] = 16'd5; exp_rows[1] = 16'd12; exp_rows[2] = 16'hFFEB; exp_rows[3] = 16'd32;
   endtask

   // Raise both loaded flags now (at a negedge) and collect all four rows with m_ready high.
   task automatic run_rows(input string tag);
      int cyc;
      int r;
      int bad;
      m_ready    = 1'b1;
      mat_loaded = 1'b1;
      vec_loaded = 1'b1;
      cyc = 0;
      r   = 0;
      while (r < 4 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (m_valid && m_ready) begin
            checks++;
            if (m_data !== exp_rows[r]) begin
               errors++;
               $display("FAIL %s row%0d data: got %0d expected %0d", tag, r,
                        $signed(m_data), $signed(exp_rows[r]));
            end
            checks++;
            if (cyc != 6 * (r + 1)) begin
               errors++;
               $display("FAIL %s row%0d timing: valid at cycle %0d expected %0d", tag, r, cyc, 6 * (r + 1));
            end
            r++;
         end
      end
      checks++;
      if (r != 4) begin
         errors++;
         $display("FAIL %s timeout: got %0d rows expected 4", tag, r);
      end
      @(negedge clk);
      checks++;
      if (mem_release !== 1'b1) begin
         errors++;
         $display("FAIL %s release_pulse: got %b expected 1", tag, mem_release);
      end
      @(negedge clk);
      checks++;
      if (mem_release !== 1'b0) begin
         errors++;
         $display("FAIL %s release_width: got %b expected 0", tag, mem_release);
      end
      mat_loaded = 1'b0;
      vec_loaded = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (mat_addr !== 4'd0 || vec_addr !== 2'd0 || m_valid !== 1'b0 || mem_release !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s release_ignores_loaded: %0d active cycles expected 0", tag, bad);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_data !== 16'd0 || mat_addr !== 4'd0 || vec_addr !== 2'd0 || mem_release !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b data=%h maddr=%h vaddr=%h rel=%b expected 0 0 0 0 0",
                  m_valid, m_data, mat_addr, vec_addr, mem_release);
      end
   endtask

   task automatic test_all_ones();
      for (int i = 0; i < 16; i++) mat_mem[i] = 8'd1;
      for (int i = 0; i < 4; i++) vec_mem[i] = 8'(i + 1);
      for (int i = 0; i < 4; i++) exp_rows[i] = 16'd10;
      run_rows("all_ones");
   endtask

   task automatic test_diag();
      load_diag();
      run_rows("diag");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 16; i++) mat_mem[i] = 8'h80;
      for (int i = 0; i < 4; i++) vec_mem[i] = 8'h80;
      for (int i = 0; i < 4; i++) exp_rows[i] = 16'd0;
      run_rows("wrap");
   endtask

   task automatic test_idle_gating();
      int bad;
      bad = 0;
      m_ready    = 1'b1;
      mat_loaded = 1'b1;
      vec_loaded = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (mat_addr !== 4'd0 || vec_addr !== 2'd0 || m_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL idle_gating: %0d active cycles expected 0", bad);
      end
      vec_loaded = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (mat_addr !== 4'd1 || vec_addr !== 2'd1) begin
         errors++;
         $display("FAIL idle_start: got maddr=%0d vaddr=%0d expected 1 1", mat_addr, vec_addr);
      end
      do_reset();
   endtask

   task automatic test_stall_and_reset();
      int cyc;
      int bad;
      load_diag();
      m_ready    = 1'b1;
      mat_loaded = 1'b1;
      vec_loaded = 1'b1;
      cyc = 0;
      while (!m_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'd5) begin
         errors++;
         $display("FAIL stall_row0: got valid=%b data=%0d expected 1 5", m_valid, $signed(m_data));
      end
      // Loaded flags dropping mid-operation must not abort it
      mat_loaded = 1'b0;
      vec_loaded = 1'b0;
      @(negedge clk);
      m_ready = 1'b0;
      cyc = 0;
      while (!m_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      bad = 0;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge clk);
         if (m_valid !== 1'b1 || m_data !== 16'd12 || mat_addr !== 4'd8 || vec_addr !== 2'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold: %0d unstable cycles expected 0 (valid=%b data=%0d maddr=%0d)",
                  bad, m_valid, $signed(m_data), mat_addr);
      end
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || mat_addr !== 4'd8 || vec_addr !== 2'd0) begin
         errors++;
         $display("FAIL row2_start: got valid=%b maddr=%0d vaddr=%0d expected 0 8 0", m_valid, mat_addr, vec_addr);
      end
      @(negedge clk);
      checks++;
      if (mat_addr !== 4'd9 || vec_addr !== 2'd1) begin
         errors++;
         $display("FAIL row2_read: got maddr=%0d vaddr=%0d expected 9 1", mat_addr, vec_addr);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || mat_addr !== 4'd0 || vec_addr !== 2'd0 || m_data !== 16'd0) begin
         errors++;
         $display("FAIL midop_reset: got valid=%b maddr=%0d vaddr=%0d data=%0d expected 0 0 0 0",
                  m_valid, mat_addr, vec_addr, m_data);
      end
      reset = 1'b0;
      run_rows("reload");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mat_mem[i] = 8'd0;
      for (int i = 0; i < 4; i++) vec_mem[i] = 8'd0;
      test_reset();
      test_all_ones();
      test_diag();
      test_wrap();
      test_idle_gating();
      test_stall_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_mvm_read.md
Name: ctrl_mvm_read

Overview:
- Downstream neighbour of the memory write controllers: once the matrix and vector memories are fully loaded, it sequences reads from both and runs a signed multiply-accumulate per matrix row.
- Presents each row result on an AXI-style master port (m_valid/m_ready).
- After the last row is accepted, pulses mem_release so the write controllers restart loading.
- Sits between the loaded memories and the output consumer in the matrix-vector multiply datapath.

Parameters:
- M, 4, vector length and matrix dimension (M x M matrix, M rows output)
- MAT_ADDR_WIDTH, 4, matrix memory address width (must hold M*M-1)
- VEC_ADDR_WIDTH, 2, vector memory address width (must hold M-1)
- DATA_WIDTH, 8, signed width of memory words
- ACC_WIDTH, 16, signed accumulator/output width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- mat_loaded  input  1  matrix memory full (level, from matrix write controller)
- vec_loaded  input  1  vector memory full (level, from vector write controller)
- mat_rdata  input  DATA_WIDTH  matrix memory read data, 1-cycle read latency
- vec_rdata  input  DATA_WIDTH  vector memory read data, 1-cycle read latency
- mat_addr  output  MAT_ADDR_WIDTH  matrix read address
- vec_addr  output  VEC_ADDR_WIDTH  vector read address
- m_valid  output  1  result valid
- m_ready  input  1  consumer ready
- m_data  output  ACC_WIDTH  row result
- mem_release  output  1  one-cycle pulse: both memories consumed, writers may reload

Behaviour:
- Interface: reset is named reset, synchronous, active-high; clock is clk.
- Reset values:
  - state IDLE
  - mat_addr = 0, vec_addr = 0
  - m_valid = 0, m_data = 0
  - mem_release = 0
  - row counter = 0, column counter = 0, accumulator = 0, read-valid pipe = 0
- FSM states and transitions:
  - IDLE: leave only when mat_loaded & vec_loaded are both 1 and mem_release is 0; go to READ.
  - READ: exactly M cycles, column counter 0..M-1. mat_addr = row*M + col, kept as a free-running counter, not a multiplier. vec_addr = col. After col = M-1, go to DRAIN.
  - DRAIN: 1 cycle; the final product is accumulated. Then go to OUT with m_valid = 1 and m_data = final sum.
  - OUT: hold m_valid and m_data stable until m_valid & m_ready.
    - On handshake with row < M-1: row+1, col = 0, vec_addr = 0, go to READ.
    - On handshake with row = M-1: go to IDLE, mat_addr = 0, row = 0, mem_release = 1 for the next cycle only.
- Read pipeline:
  - rd_vld_q = registered (state == READ). Data is consumed when rd_vld_q = 1.
  - First product of a row (col_q = 0) loads the accumulator; later products add to it. No separate clear cycle.
- Arithmetic:
  - product = signed DATA_WIDTH x signed DATA_WIDTH (2*DATA_WIDTH bits), sign-extended or truncated to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- Latency: IDLE->READ entry to m_valid high = M+1 cycles. With m_ready held high, one result every M+2 cycles.
- Boundary conditions:
  - mat_loaded or vec_loaded dropping outside IDLE is ignored; the operation completes.
  - m_ready high while not in OUT has no effect.
  - Reset mid-operation returns to IDLE immediately; any partial result is discarded and m_valid drops the next cycle.
  - During the mem_release cycle, loaded inputs are ignored, even if both are still high.

Decomposition:
- Shared package mvm_pkg:
  - state enum (IDLE, READ, DRAIN, OUT)
  - default M / width constants
  - signed data and accumulator typedefs
- One natural sub-module, mac_unit: signed multiply, load-or-accumulate, wrap. Inputs en, first, a, b; output acc.

Test Plan:
- M=4, matrix all 1, vector {1,2,3,4}, m_ready=1 -> four results of 10. m_valid first rises 5 cycles after start. mem_release pulses once, 1 cycle after the 4th handshake.
- Matrix rows {1,0,0,0},{0,2,0,0},{0,0,-3,0},{0,0,0,4}, vector {5,6,7,8} -> outputs 5, 12, -21, 32 in row order.
- All matrix and vector words -128 -> each product 16384, sum 65536 wraps to m_data = 0 for every row.
- m_ready low for 7 cycles on row 1 -> m_valid and m_data held constant, no address change. Row 2 READ starts the cycle after the handshake.
- Reset asserted during READ of row 2 -> next cycle IDLE, m_valid=0, addresses 0. Reload gives correct row-0 result.
- Only mat_loaded=1 (vec_loaded=0) for 20 cycles -> remains IDLE, no address activity. vec_loaded rising starts READ the next cycle.
